// File: rtl/raytracer_pkg.sv
// Shared raytracer geometry: a 32x32x32 voxel grid stored as a packed bitmap,
// one 32-bit word per x-row, word index {z, y}, voxel address {z, y, x}.
package raytracer_pkg;

    localparam int GRID_BITS      = 5;
    localparam int ADDR_BITS      = 3 * GRID_BITS;
    localparam int WORD_W         = 1 << GRID_BITS;
    localparam int WORD_ADDR_BITS = 2 * GRID_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_SETTLE
    } sls_state_t;

    function automatic logic [ADDR_BITS-1:0] voxel_addr(
        input logic [GRID_BITS-1:0] x,
        input logic [GRID_BITS-1:0] y,
        input logic [GRID_BITS-1:0] z
    );
        return {z, y, x};
    endfunction

endpackage

// File: rtl/scene_load_streamer.sv
// Scene-load initiator: on start, reads the packed voxel bitmap from word memory
// and streams every voxel, in ascending address order, over the raytracer
// scene-load handshake. Word n+1 is prefetched while word n shifts out, so the
// stream has no bubble at word boundaries.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      begin a full load (ignored while busy) / cancel a load
//   busy, done        load in progress / 1-cycle completion pulse
//   mem_rd_en/addr    bitmap word read request
//   mem_rd_data       read data, valid one cycle after mem_rd_en
//   load_mode/valid   scene-load mode and transfer valid to raytracer_top
//   load_ready        transfer accepted
//   load_addr/data    voxel address and occupancy bit
//   voxels_sent       accepted transfers this load
//   occupied_count    accepted transfers carrying a 1
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; counters hold the last load's totals
// ST_PRIME  | word 0 read issued, waiting one cycle for its data
// ST_STREAM | presenting voxels; next word prefetched into nxt_word
// ST_SETTLE | load_mode low, counting down before the done pulse
module scene_load_streamer
    import raytracer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_rd_en,
    output logic [WORD_ADDR_BITS-1:0] mem_rd_addr,
    input  logic [WORD_W-1:0]         mem_rd_data,
    output logic                      load_mode,
    output logic                      load_valid,
    input  logic                      load_ready,
    output logic [ADDR_BITS-1:0]      load_addr,
    output logic                      load_data,
    output logic [ADDR_BITS:0]        voxels_sent,
    output logic [ADDR_BITS:0]        occupied_count
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    sls_state_t                state, state_nxt;
    logic [WORD_W-1:0]         cur_word, nxt_word;
    logic                      nxt_valid, rd_pend;
    logic [GRID_BITS-1:0]      bit_idx;
    logic [WORD_ADDR_BITS-1:0] word_idx;
    // One bit wider than the word address so "all words read" is its MSB.
    logic [WORD_ADDR_BITS:0]   rd_ptr;
    logic [SET_W-1:0]          settle_cnt;
    logic                      done_r;
    logic [ADDR_BITS:0]        sent_r, occ_r;
    logic                      xfer, last_bit, last_xfer;

    assign xfer      = load_valid && load_ready;
    assign last_bit  = (bit_idx == '1);
    assign last_xfer = xfer && last_bit && (word_idx == '1);

    assign busy           = (state != ST_IDLE);
    assign done           = done_r;
    assign mem_rd_addr    = rd_ptr[WORD_ADDR_BITS-1:0];
    assign load_addr      = voxel_addr(bit_idx, word_idx[GRID_BITS-1:0],
                                       word_idx[WORD_ADDR_BITS-1:GRID_BITS]);
    assign load_data      = cur_word[0];
    assign voxels_sent    = sent_r;
    assign occupied_count = occ_r;

    always_comb begin
        state_nxt  = state;
        load_mode  = 1'b0;
        load_valid = 1'b0;
        mem_rd_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                load_mode = 1'b1;
                mem_rd_en = !rd_pend;
                if (rd_pend) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                load_mode  = 1'b1;
                load_valid = 1'b1;
                mem_rd_en  = !nxt_valid && !rd_pend && !rd_ptr[WORD_ADDR_BITS];
                if (last_xfer) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_word   <= '0;
            nxt_word   <= '0;
            nxt_valid  <= 1'b0;
            rd_pend    <= 1'b0;
            bit_idx    <= '0;
            word_idx   <= '0;
            rd_ptr     <= '0;
            settle_cnt <= '0;
            done_r     <= 1'b0;
            sent_r     <= '0;
            occ_r      <= '0;
        end else begin
            state   <= state_nxt;
            done_r  <= (state == ST_SETTLE) && (settle_cnt == '0) && !abort;
            rd_pend <= mem_rd_en;

            if (mem_rd_en) rd_ptr <= rd_ptr + 1'b1;

            if (rd_pend) begin
                if (state == ST_PRIME) begin
                    cur_word <= mem_rd_data;
                end else begin
                    nxt_word  <= mem_rd_data;
                    nxt_valid <= 1'b1;
                end
            end

            // A word lasts at least WORD_W cycles, so the prefetch has always
            // landed in nxt_word before the boundary transfer consumes it.
            if (xfer) begin
                sent_r  <= sent_r + 1'b1;
                occ_r   <= occ_r + (ADDR_BITS+1)'(cur_word[0]);
                bit_idx <= bit_idx + 1'b1;
                if (last_bit) begin
                    cur_word  <= nxt_word;
                    nxt_valid <= 1'b0;
                    word_idx  <= word_idx + 1'b1;
                end else begin
                    cur_word <= cur_word >> 1;
                end
            end

            if (last_xfer) begin
                settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            // Last so it overrides leftovers from an aborted load, including a
            // read still in flight when abort hit.
            if (state == ST_IDLE && start) begin
                sent_r    <= '0;
                occ_r     <= '0;
                rd_ptr    <= '0;
                rd_pend   <= 1'b0;
                nxt_valid <= 1'b0;
                bit_idx   <= '0;
                word_idx  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_scene_load_streamer.sv
module tb_scene_load_streamer;
    import raytracer_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst, start, abort, load_ready;
    logic                      busy, done, mem_rd_en, load_mode, load_valid, load_data;
    logic [WORD_ADDR_BITS-1:0] mem_rd_addr;
    logic [WORD_W-1:0]         mem_rd_data;
    logic [ADDR_BITS-1:0]      load_addr;
    logic [ADDR_BITS:0]        voxels_sent, occupied_count;

    logic [WORD_W-1:0] mem [1 << WORD_ADDR_BITS];

    scene_load_streamer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .load_mode(load_mode), .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .voxels_sent(voxels_sent), .occupied_count(occupied_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic                 s_busy, s_done, s_rd_en, s_mode, s_valid, s_data;
    logic [9:0]           s_rd_addr;
    logic [14:0]          s_addr;
    logic [15:0]          s_sent, s_occ;

    int   exp_addr, n_xfer, n_occ, n_reads, n_done, n_valid;
    int   first_valid, first_rd, busy_rise, last_xfer, done_cyc, max_rd;
    logic prev_stall, prev_data, prev_cut, last_data;
    logic [14:0] prev_addr, last_addr;
    int   ones_q[$];

    // Reference: voxel a lives in word a/32, bit a%32.
    function automatic logic exp_bit(input int a);
        int w, b;
        w = (a / 32) % 1024;
        b = a % 32;
        return mem[w][b];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        exp_addr = 0; n_xfer = 0; n_occ = 0; n_reads = 0; n_done = 0; n_valid = 0;
        first_valid = -1; first_rd = -1; busy_rise = -1; last_xfer = -1;
        done_cyc = -1; max_rd = -1;
        prev_stall = 1'b0; prev_cut = 1'b0; prev_data = 1'b0; prev_addr = '0;
        last_addr = '0; last_data = 1'b0;
        ones_q.delete();
    endtask

    // Samples one cycle at the falling edge, runs the stream monitor, then
    // advances to just after the next rising edge where inputs may change.
    task automatic cycle();
        logic eb;
        @(negedge clk);
        s_busy = busy; s_done = done; s_rd_en = mem_rd_en; s_rd_addr = mem_rd_addr;
        s_mode = load_mode; s_valid = load_valid; s_addr = load_addr; s_data = load_data;
        s_sent = voxels_sent; s_occ = occupied_count;
        if (s_valid === 1'b1) begin
            eb = exp_bit(exp_addr);
            if (first_valid < 0) first_valid = cyc;
            n_valid++;
            if (prev_stall) begin
                check("stall_addr", 32'(s_addr), 32'(prev_addr));
                check("stall_data", 32'(s_data), 32'(prev_data));
            end
            check("addr_order", 32'(s_addr), exp_addr & 32'h7fff);
            check("data", 32'(s_data), 32'(eb));
            check("mode_with_valid", 32'(s_mode), 32'd1);
            if (load_ready) begin
                n_xfer++;
                n_occ += int'(eb);
                if (s_data) ones_q.push_back(int'(s_addr));
                last_xfer = cyc; last_addr = s_addr; last_data = s_data;
                exp_addr++;
            end
        end else if (prev_stall && !prev_cut) begin
            check("valid_held", 32'(s_valid), 32'd1);
        end
        prev_stall = (s_valid === 1'b1) && load_ready == 1'b0;
        prev_addr  = s_addr;
        prev_data  = s_data;
        prev_cut   = abort || rst;
        if (s_rd_en === 1'b1) begin
            n_reads++;
            if (first_rd < 0) first_rd = cyc;
            if (int'(s_rd_addr) > max_rd) max_rd = int'(s_rd_addr);
        end
        if (s_busy === 1'b1 && busy_rise < 0) busy_rise = cyc;
        if (s_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            check("busy_low_at_done", 32'(s_busy), 32'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(s_busy), 0);
        check({tag, "_done"}, 32'(s_done), 0);
        check({tag, "_rd_en"}, 32'(s_rd_en), 0);
        check({tag, "_rd_addr"}, 32'(s_rd_addr), 0);
        check({tag, "_mode"}, 32'(s_mode), 0);
        check({tag, "_valid"}, 32'(s_valid), 0);
        check({tag, "_addr"}, 32'(s_addr), 0);
        check({tag, "_data"}, 32'(s_data), 0);
        check({tag, "_sent"}, 32'(s_sent), 0);
        check({tag, "_occ"}, 32'(s_occ), 0);
    endtask

    // One load from start to done (abort_at < 0) or to an abort issued in the
    // cycle after transfer number abort_at has been accepted.
    task automatic run_load(input int rdy_pct, input int abort_at, input logic abort_rdy,
                            input logic poke);
        int s, guard, exp_sent;
        clear_stats();
        s = cyc;
        start = 1'b1;
        load_ready = ($urandom_range(99) < rdy_pct);
        cycle();
        start = 1'b0;
        load_ready = ($urandom_range(99) < rdy_pct);
        cycle();
        check("sent_cleared", 32'(s_sent), 0);
        check("occ_cleared", 32'(s_occ), 0);
        check("busy_after_start", 32'(s_busy), 1);
        guard = 0;
        while (n_done == 0 && guard < 40000) begin
            if (abort_at >= 0 && n_xfer == abort_at) break;
            load_ready = ($urandom_range(99) < rdy_pct);
            start = poke && n_xfer < 32000 && ($urandom_range(499) == 0);
            cycle();
            guard++;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            check("abort_reached", n_xfer, abort_at);
            abort = 1'b1;
            load_ready = abort_rdy;
            cycle();
            abort = 1'b0;
            exp_sent = n_xfer;
            cycle();
            check("abort_valid", 32'(s_valid), 0);
            check("abort_mode", 32'(s_mode), 0);
            check("abort_busy", 32'(s_busy), 0);
            check("abort_rd_en", 32'(s_rd_en), 0);
            repeat (20) cycle();
            check("abort_no_done", n_done, 0);
            check("abort_sent", 32'(s_sent), exp_sent);
            check("abort_occ", 32'(s_occ), n_occ);
        end else begin
            check("done_seen", n_done, 1);
            check("first_valid_lat", first_valid - s, 3);
            check("first_rd_lat", first_rd - s, 1);
            check("busy_rise_lat", busy_rise - s, 1);
            check("xfer_count", n_xfer, 32768);
            check("sent_final", 32'(s_sent), 32768);
            check("occ_final", 32'(s_occ), n_occ);
            check("done_latency", done_cyc - last_xfer, 11);
            check("read_count", n_reads, 1024);
            check("max_rd_addr", max_rd, 1023);
            if (rdy_pct == 100) begin
                check("valid_cycles", n_valid, 32768);
                check("valid_contiguous", last_xfer - first_valid + 1, 32768);
            end
            repeat (5) cycle();
            check("single_done", n_done, 1);
            check("sent_hold", 32'(s_sent), 32768);
            check("occ_hold", 32'(s_occ), n_occ);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; load_ready = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_stats();
        cycle();
        cycle();
        check_zero("reset");

        // All-zero bitmap; start in the same cycle reset is released; stray
        // start pulses while busy must be ignored.
        rst = 1'b0;
        run_load(100, -1, 1'b0, 1'b1);
        check("t1_occ_zero", 32'(s_occ), 0);

        // Single voxel at addr 5 plus the very last voxel.
        mem[0] = 32'h0000_0020;
        mem[1023] = 32'h8000_0000;
        run_load(100, -1, 1'b0, 1'b0);
        check("t2_ones", ones_q.size(), 2);
        if (ones_q.size() > 0) check("t2_first_one", ones_q[0], 5);
        check("t3_last_addr", 32'(last_addr), 32'h7fff);
        check("t3_last_data", 32'(last_data), 1);
        check("t23_occ", 32'(s_occ), 2);

        // Random bitmap with random back-pressure, aborted twice.
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        run_load(50, 1000, 1'b0, 1'b0);
        check("t5_sent_1000", 32'(s_sent), 1000);
        run_load(50, 3000, 1'b1, 1'b0);
        check("t4_sent_coincide", 32'(s_sent), 3001);

        // Reset in the middle of a stream.
        clear_stats();
        start = 1'b1; load_ready = 1'b1;
        cycle();
        start = 1'b0;
        repeat (200) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check_zero("rst_mid");
        repeat (15) cycle();
        check("rst_no_done", n_done, 0);
        check("rst_idle", 32'(s_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
